// File: rtl/pixel_source.sv
// Pixel source: buffers upstream RGB888 words in a FIFO, aligns them to frame boundaries and feeds the timing stage.
// Define PIXEL_SOURCE_STATS_EN to add the saturating underflow_cnt output.
module pixel_source #(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int DEPTH      = 64,
    parameter int FILL_LEVEL = 32
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        frame_start,
    input  logic        pix_req,
    output logic [23:0] rgb,
    output logic        locked,
    output logic        underflow,
    output logic        misalign
`ifdef PIXEL_SOURCE_STATS_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int FRAME_PIX = HDISP * VDISP;
    localparam int IW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] FILL_C   = CW'(FILL_LEVEL);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        SEARCH,
        FILL,
        STREAM
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [24:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] pix_idx;

    logic          hs;
    logic          push;
    logic          pop;
    logic          flush;
    logic          go_stream;
    logic          underflow_evt;
    logic          misalign_evt;
    logic [24:0]   head;
    logic [PW-1:0] wr_addr;

    assign s_ready = (count < DEPTH_C) || (state == SEARCH);
    assign locked  = (state == STREAM);
    assign hs      = s_valid && s_ready;
    assign head    = mem[rd_ptr];
    // A flush rewinds the FIFO, so a word accepted in that cycle lands at slot 0.
    assign wr_addr = flush ? '0 : wr_ptr;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next    = state;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        go_stream     = 1'b0;
        underflow_evt = 1'b0;
        misalign_evt  = 1'b0;

        case (state)
            SEARCH: begin
                if (hs && s_sof) begin
                    push       = 1'b1;
                    state_next = FILL;
                end
            end

            FILL: begin
                push = hs;
                if (frame_start && (count >= FILL_C)) begin
                    state_next = STREAM;
                    go_stream  = 1'b1;
                end
            end

            STREAM: begin
                if (pix_req) begin
                    if (count == '0) begin
                        underflow_evt = 1'b1;
                    end else begin
                        pop          = 1'b1;
                        misalign_evt = (pix_idx == '0) ? !head[24] : head[24];
                    end
                end
                flush = underflow_evt || misalign_evt;
                // On a flush the incoming word is treated as if we were already searching.
                if (flush) begin
                    if (hs && s_sof) begin
                        push       = 1'b1;
                        state_next = FILL;
                    end else begin
                        state_next = SEARCH;
                    end
                end else begin
                    push = hs;
                end
            end

            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (pixel_rst) begin
            state     <= SEARCH;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pix_idx   <= '0;
            rgb       <= '0;
            underflow <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state <= state_next;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push ? PW'(1) : '0;
                count  <= push ? CW'(1) : '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (go_stream) begin
                pix_idx <= '0;
            end else if (pop) begin
                pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + IW'(1);
            end

            // A request that pops nothing (outside STREAM, or underflow) returns black.
            if (pop) begin
                rgb <= head[23:0];
            end else if (pix_req) begin
                rgb <= '0;
            end

            if (underflow_evt) underflow <= 1'b1;
            if (misalign_evt)  misalign  <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; pointers and count alone define which words are valid.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            mem[wr_addr] <= {s_sof, s_data};
        end
    end

`ifdef PIXEL_SOURCE_STATS_EN
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            underflow_cnt <= '0;
        end else if (underflow_evt && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_source.sv
// Directed bench for pixel_source: drop-to-sof, streaming, underflow, misalignment, full FIFO and mid-stream reset.
module tb_pixel_source;

    localparam int HDISP      = 4;
    localparam int VDISP      = 2;
    localparam int DEPTH      = 8;
    localparam int FILL_LEVEL = 4;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [23:0] s_data;
    logic        s_sof;
    logic        s_valid;
    logic        s_ready;
    logic        frame_start;
    logic        pix_req;
    logic [23:0] rgb;
    logic        locked;
    logic        underflow;
    logic        misalign;
`ifdef PIXEL_SOURCE_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pixel_source #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .DEPTH      (DEPTH),
        .FILL_LEVEL (FILL_LEVEL)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .rgb         (rgb),
        .locked      (locked),
        .underflow   (underflow),
        .misalign    (misalign)
`ifdef PIXEL_SOURCE_STATS_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        step();
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
    endtask

    task automatic req_pix();
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},       32'(rgb),       32'h0);
        check({tag, "_locked"},    32'(locked),    32'h0);
        check({tag, "_underflow"}, 32'(underflow), 32'h0);
        check({tag, "_misalign"},  32'(misalign),  32'h0);
        check({tag, "_s_ready"},   32'(s_ready),   32'h1);
`ifdef PIXEL_SOURCE_STATS_EN
        check({tag, "_ucnt"},      32'(underflow_cnt), 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pixel_rst   = 1'b1;
        s_data      = '0;
        s_sof       = 1'b0;
        s_valid     = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        step();
        step();
        check_reset_outputs("por");
        pixel_rst = 1'b0;

        // Non-sof words ahead of the first frame must be discarded.
        push(24'h00000A, 1'b0);
        push(24'h00000B, 1'b0);
        push(24'h00000C, 1'b0);
        check("search_locked", 32'(locked), 32'h0);
        check("search_ready",  32'(s_ready), 32'h1);

        push(24'h000001, 1'b1);
        push(24'h000002, 1'b0);
        pulse_fs();                                   // only 2 words buffered, below FILL_LEVEL
        check("fs_below_fill", 32'(locked), 32'h0);
        req_pix();
        check("fill_rgb_zero", 32'(rgb), 32'h0);

        for (int i = 3; i <= 8; i++) push(24'(i), 1'b0);
        pulse_fs();
        check("lock", 32'(locked), 32'h1);

        for (int i = 1; i <= 8; i++) begin
            req_pix();
            check($sformatf("pix%0d", i), 32'(rgb), 32'(i));
        end
        step();
        check("rgb_hold",    32'(rgb),    32'h8);
        check("still_lock",  32'(locked), 32'h1);

        // FIFO drained while streaming: underflow.
        req_pix();
        check("uf_flag",     32'(underflow), 32'h1);
        check("uf_rgb",      32'(rgb),       32'h0);
        check("uf_locked",   32'(locked),    32'h0);
        check("uf_ready",    32'(s_ready),   32'h1);
        check("uf_misalign", 32'(misalign),  32'h0);
`ifdef PIXEL_SOURCE_STATS_EN
        check("uf_cnt",      32'(underflow_cnt), 32'h1);
`endif

        // 7-word frame followed by next sof: sof appears at index 7.
        push(24'h000011, 1'b1);
        for (int i = 2; i <= 7; i++) push(24'(16 + i), 1'b0);
        push(24'h000021, 1'b1);
        check("full_ready", 32'(s_ready), 32'h0);
        pulse_fs();
        check("ma_lock", 32'(locked), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            req_pix();
            check($sformatf("ma_pix%0d", i), 32'(rgb), 32'(16 + i));
        end
        req_pix();
        check("ma_flag",   32'(misalign), 32'h1);
        check("ma_locked", 32'(locked),   32'h0);
        check("ma_ready",  32'(s_ready),  32'h1);
        req_pix();
        check("ma_search_rgb", 32'(rgb), 32'h0);

        // Full FIFO with s_valid held, then pop and simultaneous push/pop.
        push(24'h000031, 1'b1);
        for (int i = 2; i <= 8; i++) push(24'(48 + i), 1'b0);
        s_valid = 1'b1;
        s_data  = 24'h000039;
        s_sof   = 1'b0;
        check("held_full_ready", 32'(s_ready), 32'h0);
        pulse_fs();
        check("full_lock",  32'(locked),  32'h1);
        check("full_ready2", 32'(s_ready), 32'h0);
        pix_req = 1'b1;
        step();
        check("pop_rgb",   32'(rgb),     32'h31);
        check("pop_ready", 32'(s_ready), 32'h1);
        step();                                       // push 0x39 and pop 0x32 together
        check("pp_rgb",   32'(rgb),     32'h32);
        check("pp_ready", 32'(s_ready), 32'h1);
        pix_req = 1'b0;
        s_data  = 24'h00003A;
        step();                                       // push only: back to DEPTH
        check("refill_ready", 32'(s_ready), 32'h0);
        s_valid = 1'b0;
        s_data  = '0;

        // Reset mid-stream with a request pending.
        pix_req   = 1'b1;
        pixel_rst = 1'b1;
        step();
        pixel_rst = 1'b0;
        pix_req   = 1'b0;
        check_reset_outputs("mid_rst");

        push(24'h000041, 1'b1);
        for (int i = 2; i <= 4; i++) push(24'(64 + i), 1'b0);
        pulse_fs();
        check("relock", 32'(locked), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            req_pix();
            check($sformatf("relock_pix%0d", i), 32'(rgb), 32'(64 + i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_source.md
PIXEL_SOURCE -- requirements
Module: pixel_source

Interface
REQ-001 The block SHALL have parameter HDISP, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter VDISP, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning FIFO depth in words (power of two, at least 4).
REQ-004 The block SHALL have parameter FILL_LEVEL, default 32, meaning FIFO occupancy required before streaming starts (1..DEPTH).
REQ-005 The block SHALL have port pixel_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port pixel_rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-007 The block SHALL have port s_data, input, 24 bits, upstream pixel in RGB888.
REQ-008 The block SHALL have port s_sof, input, 1 bit, set on the first pixel of a frame.
REQ-009 The block SHALL have port s_valid, input, 1 bit, upstream word valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit, block accepts a word.
REQ-011 The block SHALL have port frame_start, input, 1 bit, one-cycle pulse from the timing stage, one cycle before the first active pixel of a frame.
REQ-012 The block SHALL have port pix_req, input, 1 bit, timing stage requests one pixel this cycle (active region).
REQ-013 The block SHALL have port rgb, output, 24 bits, pixel to the timing stage.
REQ-014 The block SHALL have port locked, output, 1 bit, high while in state STREAM.
REQ-015 The block SHALL have port underflow, output, 1 bit, sticky underflow flag.
REQ-016 The block SHALL have port misalign, output, 1 bit, sticky frame misalignment flag.

Function
REQ-017 The block SHALL complete a transfer when s_valid and s_ready are both high; s_data and s_sof are stored as a 25-bit FIFO word.
REQ-018 The block SHALL drive s_ready high when the FIFO count is below DEPTH, and in state SEARCH.
REQ-019 The block SHALL implement states SEARCH, FILL and STREAM.
REQ-020 In SEARCH, the block SHALL discard transfers with s_sof low; a transfer with s_sof high SHALL be written to the FIFO and the state SHALL go to FILL.
REQ-021 In FILL, the block SHALL write every transfer, and SHALL go to STREAM on frame_start when the count is at least FILL_LEVEL; otherwise it SHALL stay in FILL.
REQ-022 In STREAM, pix_req high with the FIFO non-empty SHALL pop one word, and rgb SHALL equal that word's data in the next cycle (latency 1).
REQ-023 The block SHALL keep a pixel index counting pops from 0 to HDISP*VDISP-1, wrapping to 0; it is cleared on entry to STREAM.
REQ-024 If a popped word at index 0 has sof low, or a word at a nonzero index has sof high, the block SHALL set misalign, flush the FIFO and go to SEARCH.
REQ-025 If pix_req is high in STREAM with the FIFO empty, the block SHALL set underflow, drive rgb to 0 next cycle, flush the FIFO and go to SEARCH; a push in that same cycle does not bypass.
REQ-026 In SEARCH and FILL, rgb SHALL be 0 one cycle after any pix_req, and no word SHALL be popped.
REQ-027 Push and pop in the same cycle SHALL leave the count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-028 A flush SHALL zero the count and pointers within the same cycle, and words arriving that cycle SHALL be handled per SEARCH rules.
REQ-029 rgb SHALL hold its value in cycles without a pop.

Reset
REQ-030 On pixel_rst high, the block SHALL enter state SEARCH, empty the FIFO and clear the pixel index.
REQ-031 On pixel_rst high, rgb SHALL be 0, locked 0, underflow 0, misalign 0, and s_ready 1 from the first cycle after reset.
REQ-032 Reset asserted mid-frame SHALL abandon all buffered data with no pop in that cycle.

Configuration
REQ-033 When macro PIXEL_SOURCE_STATS_EN is defined, the block SHALL add output underflow_cnt (16 bits): it resets to 0, increments on each underflow event and saturates at 65535.
REQ-034 When PIXEL_SOURCE_STATS_EN is not defined, the underflow_cnt port and its logic SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-035 Reset, then feed 3 non-sof words followed by a sof frame -> the non-sof words are dropped, the state is FILL, and the count increments from 1.
REQ-036 HDISP=4, VDISP=2, FILL_LEVEL=4, feed 0x000001..0x000008 with sof on the first word, frame_start, then 8 pix_req -> rgb=1..8 each one cycle after its req, locked=1.
REQ-037 Stream with the FIFO drained, then pix_req -> underflow=1, rgb=0 next cycle, locked=0, state SEARCH; stats build shows underflow_cnt=1.
REQ-038 Frame of 7 words followed by the next sof (HDISP*VDISP=8) -> misalign=1, FIFO flushed, state SEARCH.
REQ-039 Fill the FIFO to DEPTH with s_valid held high -> s_ready=0; one pop -> s_ready=1, and a simultaneous push/pop keeps count=DEPTH-1.
REQ-040 Assert pixel_rst mid-STREAM -> next cycle all outputs are at reset values, and a subsequent sof frame relocks.
